inst_mem_loader: RTL and testbench
==================================

# inst_mem_loader

- Sits directly upstream of the CPU core. It owns the 512×32 instruction RAM that drives the CPU's `in_inst` from `inst_addr`.
- Fills that RAM from a byte stream: a UART receiver or host bridge in the FPGA top level.
- Holds the CPU in reset (`cpu_resetN`) until a complete, checksum-verified program image has been written.

## Interface

Parameters:
- `DEPTH`, default 512: number of 32-bit RAM words; each word holds two 16-bit instructions.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

Ports:
- `clk`, input, 1: clock.
- `resetN`, input, 1: asynchronous, active-low reset.
- `rx_data`, input, 8: incoming byte.
- `rx_valid`, input, 1: `rx_data` is valid this cycle.
- `rx_ready`, output, 1: loader accepts a byte this cycle. A byte transfers when `rx_valid && rx_ready`.
- `inst_addr`, input, 9: CPU fetch address (word index).
- `in_inst`, output, 32: instruction pair to the CPU. Bits [15:0] are the even instruction, bits [31:16] the odd one.
- `cpu_resetN`, output, 1: active-low reset to the CPU.
- `load_busy`, output, 1: a frame is in progress.
- `load_done`, output, 1: last frame verified.
- `load_err`, output, 1: last frame rejected.
- `inst_count`, output, 11: instructions written in the current or last frame.

## Operation

**Frame format.** `SYNC_BYTE`, `LEN_HI`, `LEN_LO`, then 2·N payload bytes, then `CHK`.
- N is a 16-bit instruction count, 1..1024.
- Each instruction is sent low byte first.
- `CHK` is the XOR of all payload bytes.

**FSM states:** `IDLE`, `LEN_HI`, `LEN_LO`, `DATA_LO`, `DATA_HI`, `CHECK`, `DONE`, `ERR`. Transitions happen only on accepted bytes.
- `IDLE`: a byte equal to `SYNC_BYTE` → `LEN_HI`. Any other byte is discarded.
- `LEN_HI` → `LEN_LO`. From `LEN_LO`:
  - length 0 or >1024 → `ERR`;
  - otherwise clear the instruction index, XOR accumulator and `inst_count`, then → `DATA_LO`.
- `DATA_LO`: latch the byte, then → `DATA_HI`.
- `DATA_HI`: write {byte, latched_lo} to the RAM at instruction index i.
  - RAM word i[10:1]; half select i[0], where 1 = bits [31:16].
  - Increment i and `inst_count`.
  - If i+1 == N → `CHECK`; otherwise → `DATA_LO`.
- `CHECK`: byte == accumulator → `DONE`; otherwise → `ERR`.
- `DONE` / `ERR`: a `SYNC_BYTE` restarts at `LEN_HI`. Any other byte is discarded.
- The XOR accumulator updates on every accepted payload byte.

**Outputs and flags.**
- `rx_ready` is 1 in every state. Bytes are never back-pressured.
- `cpu_resetN` is 1 only in `DONE`.
- `load_busy` is 1 in `LEN_HI` through `CHECK`.
- `load_done` is 1 in `DONE`; `load_err` is 1 in `ERR`.

**Memory.**
- RAM writes are 16-bit halfword writes; the other half is untouched.
- Instructions beyond N keep their old contents.
- The read port is synchronous and independent of loading: `in_inst` <= ram[`inst_addr`] every clock.

## Timing

**Reset values:**
- state `IDLE`;
- `cpu_resetN` 0, `rx_ready` 0, `load_busy` 0, `load_done` 0, `load_err` 0, `inst_count` 0;
- `in_inst` 0.

`rx_ready` rises on the first clock after `resetN` deasserts.

**Cycle-level behaviour:**
- Every control output is registered and reflects the state after the accepting edge:
  - `cpu_resetN` rises on the edge that accepts a matching `CHK`;
  - `cpu_resetN` falls on the edge that accepts a `SYNC_BYTE` in `DONE` or `ERR`.
- The RAM write occurs on the edge that accepts the high byte. Data is readable at the next edge.
- Read latency is 1 cycle. The CPU presents `next_pc[9:1]` so that `in_inst` is valid when `pc` updates.

**Boundary conditions:**
- N = 1024 fills the RAM exactly, with no wrap.
- Odd N leaves the upper half of the last word unchanged.
- Reset mid-frame: state `IDLE`, `cpu_resetN` 0, RAM contents retained (not cleared).
- A `SYNC_BYTE` value inside the payload is plain data.

## Structure

- `loader_pkg` holds: the state enum, `SYNC_BYTE`, `MAX_INST` = 1024, and the frame-field widths.
- One sub-module, `inst_ram`:
  - DEPTH×32 storage;
  - one write port with a 2-bit halfword enable;
  - one synchronous read port;
  - written so it infers block RAM.
- The FSM, XOR accumulator and counters live in `inst_mem_loader`.

## Test plan

- Frame A5 00 02 34 12 78 56 CHK=0x08 → word0 = 0x56781234; `cpu_resetN` rises on the CHK edge; `inst_count` = 2.
- Same frame with CHK=0x09 → `load_err` = 1; `cpu_resetN` stays 0; word0 is still written.
- LEN = 0x0000, then separately LEN = 0x0401 → `ERR` immediately after `LEN_LO` in both cases.
- After a `DONE` with 3 instructions, send a new A5 frame → `cpu_resetN` falls on the sync edge; word1[31:16] keeps its old value when the new N = 3.
- Assert `resetN` low after 3 payload bytes → all outputs at reset values; earlier RAM words unchanged on read-back.
- Full 1024-instruction frame with random `rx_valid` gaps → every RAM word matches; `inst_count` = 1024; `load_done` = 1.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: frame constants,
// field widths and the loader state encoding.
package loader_pkg;

  // Default frame start marker
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  // Largest instruction count a frame may carry (fills a 512x32 RAM)
  localparam logic [15:0] MAX_INST  = 16'd1024;

  // Frame field widths
  localparam int BYTE_W = 8;
  localparam int LEN_W  = 16;
  localparam int CNT_W  = 11;
  localparam int INST_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_LO,
    DATA_HI,
    CHECK,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/inst_ram.sv
// DEPTH x 32 instruction RAM: one halfword-enabled write port and one
// synchronous read port. The array itself has no reset so it maps onto
// block RAM; only the read-data register is cleared by resetN.
module inst_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic [1:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:DEPTH-1];

  // Halfword writes: each enable bit touches only its own 16-bit lane
  always_ff @(posedge clk) begin
    if (we[0]) mem[waddr][15:0]  <= wdata[15:0];
    if (we[1]) mem[waddr][31:16] <= wdata[31:16];
  end

  // Registered read, one cycle of latency, independent of writes
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) rdata <= '0;
    else         rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a checksummed program image from a byte stream into the CPU's
// instruction RAM and holds the CPU in reset until a frame verifies.
// Frame: SYNC, LEN_HI, LEN_LO, 2*N payload bytes (low byte first), CHK.
module inst_mem_loader #(
  parameter int         DEPTH     = 512,
  parameter logic [7:0] SYNC_BYTE = loader_pkg::SYNC_BYTE
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [8:0]  inst_addr,
  output logic [31:0] in_inst,
  output logic        cpu_resetN,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_err,
  output logic [10:0] inst_count
);

  import loader_pkg::*;

  localparam int AW = $clog2(DEPTH);

  state_t              state;
  state_t              state_nxt;
  logic                accept;
  logic [BYTE_W-1:0]   len_hi_q;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    idx_q;
  logic [BYTE_W-1:0]   lo_byte_q;
  logic [BYTE_W-1:0]   xor_acc_q;
  logic [LEN_W-1:0]    len_full;
  logic                len_bad;
  logic                last_inst;
  logic [1:0]          ram_we;
  logic [AW-1:0]       ram_waddr;
  logic [WORD_W-1:0]   ram_wdata;
  logic [AW-1:0]       ram_raddr;

  assign accept    = rx_valid && rx_ready;
  assign len_full  = {len_hi_q, rx_data};
  assign len_bad   = (len_full == '0) || (len_full > MAX_INST);
  assign last_inst = (CNT_W'(idx_q + 1'b1) == len_q);

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; the FSM only advances on accepted bytes
  always_comb begin
    state_nxt = state;
    if (accept) begin
      unique case (state)
        IDLE, DONE, ERR: if (rx_data == SYNC_BYTE) state_nxt = LEN_HI;
        LEN_HI:          state_nxt = LEN_LO;
        LEN_LO:          state_nxt = len_bad ? ERR : DATA_LO;
        DATA_LO:         state_nxt = DATA_HI;
        DATA_HI:         state_nxt = last_inst ? CHECK : DATA_LO;
        CHECK:           state_nxt = (rx_data == xor_acc_q) ? DONE : ERR;
        default:         state_nxt = IDLE;
      endcase
    end
  end

  // Frame data capture: length, pending low byte and payload checksum
  always_ff @(posedge clk) begin
    if (accept) begin
      unique case (state)
        LEN_HI:  len_hi_q <= rx_data;
        LEN_LO: begin
          len_q     <= len_full[CNT_W-1:0];
          xor_acc_q <= '0;
        end
        DATA_LO: begin
          lo_byte_q <= rx_data;
          xor_acc_q <= xor_acc_q ^ rx_data;
        end
        DATA_HI: xor_acc_q <= xor_acc_q ^ rx_data;
        default: ;
      endcase
    end
  end

  // Instruction index, doubling as the reported instruction count
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      idx_q <= '0;
    end else if (accept) begin
      if (state == LEN_LO && !len_bad) idx_q <= '0;
      else if (state == DATA_HI)       idx_q <= CNT_W'(idx_q + 1'b1);
    end
  end

  assign inst_count = idx_q;

  // Halfword write on the edge that accepts the high byte; index bit 0
  // picks the lane, the remaining bits pick the word
  always_comb begin
    ram_we    = 2'b00;
    ram_waddr = idx_q[AW:1];
    ram_wdata = {rx_data, lo_byte_q, rx_data, lo_byte_q};
    if (accept && state == DATA_HI) ram_we = {idx_q[0], ~idx_q[0]};
  end

  assign ram_raddr = AW'(inst_addr);

  // Control outputs registered from the next state so they change on
  // the accepting edge itself
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rx_ready   <= 1'b0;
      cpu_resetN <= 1'b0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      rx_ready   <= 1'b1;
      cpu_resetN <= (state_nxt == DONE);
      load_busy  <= (state_nxt inside {LEN_HI, LEN_LO, DATA_LO, DATA_HI, CHECK});
      load_done  <= (state_nxt == DONE);
      load_err   <= (state_nxt == ERR);
    end
  end

  inst_ram #(
    .DEPTH (DEPTH)
  ) u_inst_ram (
    .clk    (clk),
    .resetN (resetN),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .raddr  (ram_raddr),
    .rdata  (in_inst)
  );

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: directed frame sequence with random payloads
// and random rx_valid gaps, checked against an instruction-level model.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        resetN;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [8:0]  inst_addr;
  logic [31:0] in_inst;
  logic        cpu_resetN;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic [10:0] inst_count;

  int checks = 0;
  int errors = 0;

  // Expected RAM contents, one entry per 16-bit instruction
  logic [15:0] model_inst [0:1023];
  // Payload of the frame about to be sent
  logic [15:0] frame      [0:1023];

  inst_mem_loader dut (
    .clk        (clk),
    .resetN     (resetN),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .inst_addr  (inst_addr),
    .in_inst    (in_inst),
    .cpu_resetN (cpu_resetN),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .inst_count (inst_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic busy, input logic done,
                           input logic err, input logic cpu);
    chk({tag, "_busy"}, 32'(load_busy),  32'(busy));
    chk({tag, "_done"}, 32'(load_done),  32'(done));
    chk({tag, "_err"},  32'(load_err),   32'(err));
    chk({tag, "_cpu"},  32'(cpu_resetN), 32'(cpu));
  endtask

  // One byte, preceded by 0..max_gap idle cycles; returns 1 time unit
  // after the accepting edge
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic rand_frame(input int n);
    for (int i = 0; i < n; i++) frame[i] = 16'($urandom);
  endtask

  // Complete frame from frame[0..n-1]; bad_chk corrupts the checksum
  task automatic send_frame(input int n, input bit bad_chk, input int gap);
    logic [7:0] x;
    x = 8'h00;
    send_byte(8'hA5, gap);
    chk("sync_busy", 32'(load_busy), 32'd1);
    chk("sync_cpu",  32'(cpu_resetN), 32'd0);
    send_byte(8'(n >> 8), gap);
    send_byte(8'(n), gap);
    for (int i = 0; i < n; i++) begin
      send_byte(frame[i][7:0], gap);
      send_byte(frame[i][15:8], gap);
      model_inst[i] = frame[i];
      x = x ^ frame[i][7:0] ^ frame[i][15:8];
    end
    chk("prechk_cpu",   32'(cpu_resetN), 32'd0);
    chk("prechk_busy",  32'(load_busy),  32'd1);
    chk("prechk_count", 32'(inst_count), 32'(n));
    send_byte(bad_chk ? (x ^ 8'h01) : x, gap);
    if (bad_chk) chk_flags("frame_bad", 1'b0, 1'b0, 1'b1, 1'b0);
    else         chk_flags("frame_ok",  1'b0, 1'b1, 1'b0, 1'b1);
    chk("frame_count", 32'(inst_count), 32'(n));
  endtask

  task automatic readback_all(input string tag);
    for (int w = 0; w < 512; w++) begin
      inst_addr = 9'(w);
      @(posedge clk); #1;
      chk($sformatf("%s_word%0d", tag, w), in_inst, {model_inst[2*w+1], model_inst[2*w]});
    end
  endtask

  initial begin
    resetN    = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    inst_addr = 9'd0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_ready", 32'(rx_ready),   32'd0);
    chk("reset_count", 32'(inst_count), 32'd0);
    chk("reset_inst",  in_inst,         32'd0);
    resetN = 1'b1;
    #1;
    chk("ready_before_edge", 32'(rx_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready_after_edge", 32'(rx_ready), 32'd1);

    // Non-sync bytes in IDLE are ignored
    send_byte(8'h3C, 0);
    send_byte(8'h00, 1);
    chk_flags("idle_junk", 1'b0, 1'b0, 1'b0, 1'b0);

    // Full 1024-instruction image with random gaps fills every word
    rand_frame(1024);
    send_frame(1024, 1'b0, 3);
    readback_all("full");

    // Known small frame; cpu_resetN falls on the sync edge out of DONE
    frame[0] = 16'h1234;
    frame[1] = 16'h5678;
    send_frame(2, 1'b0, 0);
    inst_addr = 9'd0;
    @(posedge clk); #1;
    chk("known_word0", in_inst, 32'h5678_1234);

    // Same frame with checksum 0x09: rejected but still written
    send_frame(2, 1'b1, 0);
    rand_frame(2);
    send_frame(2, 1'b1, 1);
    inst_addr = 9'd0;
    @(posedge clk); #1;
    chk("badchk_word0", in_inst, {model_inst[1], model_inst[0]});

    // Length 0 and length 1025 go straight to ERR
    send_byte(8'hA5, 0);
    chk_flags("len0_sync", 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk_flags("len0", 1'b0, 1'b0, 1'b1, 1'b0);
    send_byte(8'hA5, 0);
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    chk_flags("len1025", 1'b0, 1'b0, 1'b1, 1'b0);

    // Two back-to-back N=3 frames; upper half of word1 stays untouched
    rand_frame(3);
    send_frame(3, 1'b0, 2);
    rand_frame(3);
    send_frame(3, 1'b0, 2);
    readback_all("n3");

    // Sync value inside the payload is plain data
    frame[0] = 16'hA5A5;
    frame[1] = 16'h00A5;
    send_frame(2, 1'b0, 1);

    // Odd length leaves upper half of last word as it was
    rand_frame(5);
    send_frame(5, 1'b0, 1);
    readback_all("odd");

    // Reset after three payload bytes: only the first instruction lands
    rand_frame(4);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_byte(frame[0][7:0], 1);
    send_byte(frame[0][15:8], 1);
    model_inst[0] = frame[0];
    send_byte(frame[1][7:0], 1);
    chk("midframe_count", 32'(inst_count), 32'd1);
    #2 resetN = 1'b0;
    #1;
    chk_flags("midreset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midreset_ready", 32'(rx_ready),   32'd0);
    chk("midreset_count", 32'(inst_count), 32'd0);
    chk("midreset_inst",  in_inst,         32'd0);
    @(posedge clk); #1;
    resetN = 1'b1;
    @(posedge clk); #1;
    chk("midreset_ready_back", 32'(rx_ready), 32'd1);
    readback_all("after_reset");

    // A clean frame still loads after the interrupted one
    rand_frame(7);
    send_frame(7, 1'b0, 2);
    readback_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
